// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write side.
// The 2:4 and 3:8 decode helpers are the leaves of the 5:32 write-enable tree.
package regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG_IDX = 5'd31;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    function automatic logic [3:0] dec2_4(input logic en, input logic [1:0] a);
        dec2_4 = en ? (4'b0001 << a) : 4'b0000;
    endfunction

    function automatic logic [7:0] dec3_8(input logic en, input logic [2:0] a);
        dec3_8 = en ? (8'b0000_0001 << a) : 8'b0000_0000;
    endfunction

endpackage

// File: rtl/decoder5_32.sv
// Combinational 5:32 one-hot decoder with enable.
// The upper two address bits pick one of four 3:8 groups, matching the read mux tree.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic                 en_i,
    input  reg_addr_t            addr_i,
    output logic [REG_COUNT-1:0] y_o
);

    logic [3:0] grp_en;

    assign grp_en = dec2_4(en_i, addr_i[4:3]);

    for (genvar g = 0; g < 4; g++) begin : g_grp
        assign y_o[g*8 +: 8] = dec3_8(grp_en[g], addr_i[2:0]);
    end

endmodule

// File: rtl/regfile_write_port.sv
// Register-file write side: one-stage write-back pipe, one-hot write decode and
// 32 x WIDTH storage. The in-flight write is exposed on pend_* for read bypass.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = int'(ZERO_REG_IDX)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [REG_COUNT-1:0]       we_onehot,
    output logic                       pend_valid,
    output logic [ADDR_W-1:0]          pend_addr,
    output logic [WIDTH-1:0]           pend_data,
    output logic [REG_COUNT*WIDTH-1:0] regs_q
);

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

    logic             pend_valid_q, pend_valid_d;
    reg_addr_t        pend_addr_q,  pend_addr_d;
    logic [WIDTH-1:0] pend_data_q,  pend_data_d;

    // Zero-register writes are dropped here so they never reach the decoder.
    always_comb begin
        pend_valid_d = wr_en && (wr_addr != ZERO_ADDR);
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (pend_valid_d) begin
            pend_addr_d = wr_addr;
            pend_data_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign pend_data  = pend_data_q;

    decoder5_32 u_we_dec (
        .en_i   (pend_valid_q),
        .addr_i (pend_addr_q),
        .y_o    (we_onehot)
    );

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_slot
        if (i == ZERO_REG) begin : g_zero
            assign regs_q[i*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] slot_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_q <= '0;
                end else if (we_onehot[i]) begin
                    slot_q <= pend_data_q;
                end
            end

            assign regs_q[i*WIDTH +: WIDTH] = slot_q;
        end
    end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the register file. The read side selects one of 32 registers per bit through 32:1 mux trees; this block does the opposite direction.
- Decodes a 5-bit write address into a one-hot write enable and holds the 32 x WIDTH register storage.
- A one-stage registered write-back pipe sits in front of the storage and exposes the in-flight write for read-side bypass.
- Register 31 is the hard-wired zero register.

Parameters:
- WIDTH, 64, data width of each register.
- ZERO_REG, 31, index of the constant-zero register; writes to it are discarded.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request valid this cycle.
- wr_addr  input  5  destination register index.
- wr_data  input  WIDTH  write data.
- we_onehot  output  32  decoded write enables for the current cycle. Registered stage; at most one bit high.
- pend_valid  output  1  a write is in flight this cycle and commits at the next edge.
- pend_addr  output  5  address of the in-flight write.
- pend_data  output  WIDTH  data of the in-flight write, for read-side bypass.
- regs_q  output  32*WIDTH  flattened storage; register i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset is synchronous, active-high, one clock, one synchronous reset.
- Asserting reset at an edge forces the following, regardless of wr_en:
  - all 32 registers to 0;
  - pend_valid=0, pend_addr=0, pend_data=0;
  - we_onehot=0.
- Stage capture, edge N:
  - If wr_en=1 and wr_addr!=ZERO_REG: pend_valid<=1, pend_addr<=wr_addr, pend_data<=wr_data.
  - Otherwise pend_valid<=0. pend_addr and pend_data hold their previous values (don't-care).
- Decode, during cycle N+1:
  - we_onehot = pend_valid ? (1 << pend_addr) : 0.
  - Purely combinational from the stage registers.
- Commit, edge N+1: every register i with we_onehot[i]=1 loads pend_data.
- Latency: a request presented before edge N is visible in regs_q after edge N+1, i.e. two edges.
  - Read-side logic needs the bypass (pend_*) to see the write one cycle earlier.
- Throughput: one write per cycle. Back-to-back writes pipeline with no bubbles.
- Same address on consecutive cycles: commits happen in request order; the later write wins.
- ZERO_REG handling:
  - A write to ZERO_REG never sets pend_valid and never sets we_onehot[ZERO_REG].
  - regs_q slot ZERO_REG reads 0 at all times.
- wr_en=0: wr_addr and wr_data are ignored, even when X.
- Reset while a write is pending: the pending write is discarded and never commits.
- Unaddressed registers hold their values on every edge.
- No reset-value or storage behaviour depends on WIDTH other than the data width.

Decomposition:
- Package regfile_pkg holds:
  - REG_COUNT=32
  - ADDR_W=5
  - ZERO_REG_IDX=5'd31
  - typedef reg_addr_t (logic [ADDR_W-1:0])
- Sub-module decoder5_32: combinational 5:32 one-hot decoder with enable input.
  - Built as a decoder2_4 on addr[4:3] gating four decoder3_8 on addr[2:0].
  - This mirrors the read mux tree structure.
  - Instantiated once for we_onehot.
- Storage: a generate loop of WIDTH-wide enable flops. Slot ZERO_REG is tied to 0.

Test Plan:
- Reset: hold reset 2 cycles with wr_en=1, wr_addr=5, wr_data=64'hFFFF -> all regs_q slots 0, pend_valid=0, we_onehot=0; release, idle 2 cycles -> still all 0.
- Single write: wr_en=1, addr=3, data=64'hDEAD_BEEF_0123_4567 for one cycle.
  - Next cycle: pend_valid=1, pend_addr=3, we_onehot=32'h0000_0008.
  - Following edge: slot 3 = that value, all other slots 0.
- Back-to-back writes:
  - Stimulus: addr 7 <- 64'h1, then addr 7 <- 64'h2, then addr 30 <- 64'h3 on consecutive cycles.
  - Response: we_onehot sequence 0x80, 0x80, 0x4000_0000; final slot 7=2, slot 30=3.
- Zero register: wr_en=1, addr=31, data=64'hFFFF_FFFF_FFFF_FFFF -> pend_valid=0, we_onehot=0, slot 31 remains 0.
- Reset mid-operation: write addr=12, data=64'hABCD; assert reset on the very next edge -> slot 12 = 0, pend_valid=0.
- Sweep with wr_en gating:
  - for i=0..31, write data=i*64'h0101 at addr i; then one cycle with wr_en=0, addr=4, data=X.
  - Response: slot i = i*64'h0101 for i<31, slot 31 = 0, slot 4 unchanged.
  - Every observed we_onehot is $onehot0.
